// File: rtl/rnoc_pkg.sv
// rnoc_pkg: shared flit types, port encodings, field offsets and XY routing for the router
package rnoc_pkg;
  localparam int NUM_PORTS = 5;
  typedef enum logic [1:0] {BODY = 2'b00, TAIL = 2'b01, HEAD = 2'b10, SINGLE = 2'b11} flit_type_e;
  typedef enum logic [2:0] {P_LOCAL = 3'd0, P_NORTH = 3'd1, P_EAST = 3'd2, P_SOUTH = 3'd3, P_WEST = 3'd4} port_e;
  typedef enum logic {IDLE, ACTIVE} vc_state_e;
  localparam logic [NUM_PORTS-1:0] OH_LOCAL = 5'b00001;
  localparam logic [NUM_PORTS-1:0] OH_NORTH = 5'b00010;
  localparam logic [NUM_PORTS-1:0] OH_EAST  = 5'b00100;
  localparam logic [NUM_PORTS-1:0] OH_SOUTH = 5'b01000;
  localparam logic [NUM_PORTS-1:0] OH_WEST  = 5'b10000;
  function automatic int y_lsb(int dw);
    return dw;
  endfunction
  function automatic int x_lsb(int dw, int cw);
    return dw + cw;
  endfunction
  function automatic int vc_lsb(int dw, int cw);
    return dw + 2 * cw;
  endfunction
  function automatic int type_lsb(int dw, int vcw, int cw);
    return dw + 2 * cw + vcw;
  endfunction
  function automatic logic is_head(logic [1:0] t);
    return t == HEAD || t == SINGLE;
  endfunction
  function automatic logic is_tail(logic [1:0] t);
    return t == TAIL || t == SINGLE;
  endfunction
  // X is resolved before Y; coordinates are zero-extended so compares stay unsigned
  function automatic logic [NUM_PORTS-1:0] xy_route(logic [15:0] cx, logic [15:0] cy,
                                                    logic [15:0] dx, logic [15:0] dy);
    return dx > cx ? OH_EAST : dx < cx ? OH_WEST : dy > cy ? OH_NORTH : dy < cy ? OH_SOUTH : OH_LOCAL;
  endfunction
endpackage

// File: rtl/vc_fifo.sv
// vc_fifo: single-clock FIFO with registered storage, front-of-queue output and full/empty flags
module vc_fifo #(
  parameter int DATA_WIDTH = 76,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_wr, do_rd;
  assign full  = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign empty = wp == rp;
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign dout  = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(do_wr);
      rp <= rp + (AW+1)'(do_rd);
    end
  end
  always_ff @(posedge clk) begin
    if (do_wr) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/inputport_vc.sv
// inputport_vc: router input port with per-VC FIFOs, per-packet XY routing and round-robin switch requests
module inputport_vc
  import rnoc_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_VC = 4,
  parameter int VC_DEPTH = 4,
  parameter int COORD_W = 4,
  localparam int VC_W = $clog2(NUM_VC),
  localparam int FLIT_WIDTH = DATA_WIDTH + 2 + VC_W + 2 * COORD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flit_valid,
  input  logic [FLIT_WIDTH-1:0] Flit_in,
  input  logic [COORD_W-1:0]    cur_x,
  input  logic [COORD_W-1:0]    cur_y,
  output logic                  sw_req,
  output logic [NUM_PORTS-1:0]  sw_req_port,
  output logic [VC_W-1:0]       sw_req_vc,
  input  logic                  grant,
  output logic [FLIT_WIDTH-1:0] Flit_out,
  output logic                  credit_valid,
  output logic [VC_W-1:0]       credit_vc,
  output logic [NUM_VC-1:0]     port_req,
  output logic                  overflow_err,
  output logic                  proto_err
);
  localparam int YL = y_lsb(DATA_WIDTH);
  localparam int XL = x_lsb(DATA_WIDTH, COORD_W);
  localparam int VL = vc_lsb(DATA_WIDTH, COORD_W);
  localparam int TL = type_lsb(DATA_WIDTH, VC_W, COORD_W);
  logic [FLIT_WIDTH-1:0] front [NUM_VC];
  logic [NUM_VC-1:0] hit, full, empty, wr_en, rd_en, elig;
  vc_state_e state_q [NUM_VC], state_d [NUM_VC];
  logic [NUM_PORTS-1:0] route_q [NUM_VC], route_d [NUM_VC];
  logic [VC_W-1:0] rr_ptr, sel;
  logic [VC_W:0] k;
  logic any, fire, proto_d;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign hit[v]   = flit_valid && Flit_in[VL +: VC_W] == VC_W'(v);
    assign wr_en[v] = hit[v] && !full[v];
    assign elig[v]  = state_q[v] == ACTIVE && !empty[v];
    vc_fifo #(.DATA_WIDTH(FLIT_WIDTH), .DEPTH(VC_DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .wr_en(wr_en[v]), .din(Flit_in), .rd_en(rd_en[v]),
      .dout(front[v]), .full(full[v]), .empty(empty[v])
    );
  end

  // scan downward so the eligible VC closest after rr_ptr wins
  always_comb begin
    sel = '0;
    k = '0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      k = {1'b0, rr_ptr} + (VC_W+1)'(i);
      k = k >= (VC_W+1)'(NUM_VC) ? k - (VC_W+1)'(NUM_VC) : k;
      sel = elig[k[VC_W-1:0]] ? k[VC_W-1:0] : sel;
    end
  end

  assign any         = |elig;
  assign fire        = any && grant;
  assign sw_req      = any;
  assign sw_req_vc   = sel;
  assign sw_req_port = any ? route_q[sel] : '0;
  assign Flit_out    = any ? front[sel] : '0;
  assign port_req    = ~empty;

  always_comb begin
    proto_d = 1'b0;
    rd_en = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      state_d[i] = state_q[i];
      route_d[i] = route_q[i];
      if (state_q[i] == IDLE && !empty[i]) begin
        if (is_head(front[i][TL +: 2])) begin
          state_d[i] = ACTIVE;
          route_d[i] = xy_route(16'(cur_x), 16'(cur_y), 16'(front[i][XL +: COORD_W]), 16'(front[i][YL +: COORD_W]));
        end else begin
          rd_en[i] = 1'b1;
          proto_d = 1'b1;
        end
      end else if (fire && sel == VC_W'(i)) begin
        rd_en[i] = 1'b1;
        state_d[i] = is_tail(front[i][TL +: 2]) ? IDLE : ACTIVE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_VC; i++) begin
        state_q[i] <= IDLE;
        route_q[i] <= '0;
      end
      rr_ptr       <= '0;
      credit_valid <= 1'b0;
      credit_vc    <= '0;
      overflow_err <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        state_q[i] <= state_d[i];
        route_q[i] <= route_d[i];
      end
      rr_ptr       <= fire ? (sel == VC_W'(NUM_VC - 1) ? '0 : sel + 1'b1) : rr_ptr;
      credit_valid <= fire;
      credit_vc    <= fire ? sel : credit_vc;
      overflow_err <= overflow_err || |(hit & full);
      proto_err    <= proto_err || proto_d;
    end
  end
endmodule
